mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 133 +++++++++++++
 tb/tb_mem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: 2^ADDR_W x 16-bit word memory with one-cycle read latency.
// Define MEM_BURST_CHECK_EN to add the burst sequence checker (burst_idx, seq_err).
module mem_responder #(
  parameter int ADDR_W = 10
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] Addr,
  input  logic        RD,
  input  logic        WR,
  input  logic        V,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        err,
  output logic [3:0]  burst_idx,
  output logic        seq_err
);

  logic [15:0]       r_mem [2**ADDR_W];
  logic [15:0]       r_rd_data;
  logic              r_rd_valid;
  logic              r_err;

  logic [ADDR_W-1:0] w_idx;
  logic              w_legal;
  logic              w_rd;
  logic              w_wr;
  logic              w_any;
  logic              w_err;

  assign w_idx   = Addr[ADDR_W-1:0];
  assign w_legal = (Addr >> ADDR_W) == 16'd0;
  assign w_rd    = RD & ~WR;
  assign w_wr    = WR & ~RD;
  assign w_any   = RD | WR;
  assign w_err   = (RD & WR) | (w_any & ~w_legal);

  // Storage is deliberately left out of reset.
  always_ff @(posedge Clk1) begin
    if (!Reset && w_wr && w_legal) begin
      r_mem[w_idx] <= wr_data;
    end
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      r_rd_data  <= 16'h0000;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      r_err      <= w_err;
      if (w_rd) begin
        r_rd_data <= w_legal ? r_mem[w_idx] : 16'h0000;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign err      = r_err;

`ifdef MEM_BURST_CHECK_EN
  typedef enum logic [1:0] {
    IDLE,
    RBURST,
    WBURST
  } state_t;

  state_t      r_state;
  logic [15:0] r_base;
  logic [3:0]  r_cnt;
  logic [3:0]  r_bidx;
  logic        r_seq;

  logic        w_start;
  logic        w_dir_ok;
  logic        w_addr_ok;

  assign w_start   = V & w_legal & (w_rd | w_wr);
  assign w_dir_ok  = (r_state == WBURST) ? w_wr : w_rd;
  assign w_addr_ok = Addr == (r_base + {12'd0, r_cnt});

  // r_cnt is the index the next in-burst access must carry.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      r_state <= IDLE;
      r_base  <= 16'h0000;
      r_cnt   <= 4'd0;
      r_bidx  <= 4'd0;
      r_seq   <= 1'b0;
    end else begin
      r_seq <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= w_wr ? WBURST : RBURST;
            r_base  <= Addr;
            r_cnt   <= 4'd1;
            r_bidx  <= 4'd0;
          end
        end
        RBURST, WBURST: begin
          if (!V) begin
            r_state <= IDLE;
          end else if (w_err || !w_dir_ok || !w_addr_ok) begin
            r_seq   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_bidx <= r_cnt;
            r_cnt  <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign burst_idx = r_bidx;
  assign seq_err   = r_seq;
`else
  logic w_unused_v;

  assign w_unused_v = V;
  assign burst_idx  = 4'd0;
  assign seq_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vectors checked against a behavioural memory/burst model.
// Works with or without MEM_BURST_CHECK_EN defined.
module tb_mem_responder;

  localparam int AW = 10;
`ifdef MEM_BURST_CHECK_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        Clk1 = 1'b0;
  logic        Reset = 1'b1;
  logic        RD = 1'b0;
  logic        WR = 1'b0;
  logic        V = 1'b0;
  logic [15:0] Addr = 16'h0000;
  logic [15:0] wr_data = 16'h0000;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        err;
  logic [3:0]  burst_idx;
  logic        seq_err;

  int n_checks = 0;
  int n_fail = 0;

  mem_responder #(.ADDR_W(AW)) dut (
    .Clk1      (Clk1),
    .Reset     (Reset),
    .Addr      (Addr),
    .RD        (RD),
    .WR        (WR),
    .V         (V),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .err       (err),
    .burst_idx (burst_idx),
    .seq_err   (seq_err)
  );

  always #5 Clk1 = ~Clk1;

  // Model: word array plus a "written" flag, and a burst described as
  // (active, direction, base, next element number).
  logic [15:0] m_mem [2**AW];
  bit          m_known [2**AW];
  bit          m_in = 1'b0;
  bit          m_wdir = 1'b0;
  logic [15:0] m_base = 16'h0000;
  logic [4:0]  m_k = 5'd0;

  logic [15:0] e_data = 16'h0000;
  bit          e_known = 1'b0;
  bit          e_valid = 1'b0;
  bit          e_err = 1'b0;
  bit          e_seq = 1'b0;
  logic [3:0]  e_idx = 4'd0;
  bit          e_live = 1'b0;

  logic          c_legal, c_rd, c_wr, c_err, c_ok;
  logic [AW-1:0] c_idx;
  logic          n_in, n_wdir, n_seq;
  logic [15:0]   n_base;
  logic [4:0]    n_k;
  logic [3:0]    n_idx;

  always_comb begin
    c_idx   = Addr[AW-1:0];
    c_legal = Addr < 16'(2**AW);
    c_rd    = RD && !WR;
    c_wr    = WR && !RD;
    c_err   = (RD && WR) || ((RD || WR) && !c_legal);
    c_ok    = (c_rd || c_wr) && c_legal;
    n_in    = m_in;
    n_wdir  = m_wdir;
    n_base  = m_base;
    n_k     = m_k;
    n_idx   = e_idx;
    n_seq   = 1'b0;
    if (!BURST) begin
      n_in  = 1'b0;
      n_idx = 4'd0;
    end else if (!m_in) begin
      if (V && c_ok) begin
        n_in   = 1'b1;
        n_wdir = c_wr;
        n_base = Addr;
        n_k    = 5'd1;
        n_idx  = 4'd0;
      end
    end else if (!V) begin
      n_in = 1'b0;
    end else if (c_err || !(c_rd || c_wr) || (c_wr != m_wdir)
                 || (Addr != 16'(m_base + 16'(m_k)))) begin
      n_seq = 1'b1;
      n_in  = 1'b0;
    end else begin
      n_idx = m_k[3:0];
      n_k   = m_k + 5'd1;
      if (m_k == 5'd15) n_in = 1'b0;
    end
  end

  always @(posedge Clk1) begin
    e_live <= 1'b1;
    if (Reset) begin
      e_data  <= 16'h0000;
      e_known <= 1'b1;
      e_valid <= 1'b0;
      e_err   <= 1'b0;
      e_seq   <= 1'b0;
      e_idx   <= 4'd0;
      m_in    <= 1'b0;
      m_k     <= 5'd0;
    end else begin
      e_valid <= c_rd;
      e_err   <= c_err;
      e_seq   <= n_seq;
      e_idx   <= n_idx;
      m_in    <= n_in;
      m_wdir  <= n_wdir;
      m_base  <= n_base;
      m_k     <= n_k;
      if (c_rd) begin
        e_data  <= c_legal ? m_mem[c_idx] : 16'h0000;
        e_known <= !c_legal || m_known[c_idx];
      end
      if (c_wr && c_legal) begin
        m_mem[c_idx]   <= wr_data;
        m_known[c_idx] <= 1'b1;
      end
    end
  end

  task automatic chk16(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk1) begin
    if (e_live) begin
      chk1("rd_valid", rd_valid, e_valid);
      chk1("err", err, e_err);
      chk1("seq_err", seq_err, e_seq);
      chk16("burst_idx", 16'(burst_idx), 16'(e_idx));
      if (e_known) chk16("rd_data", rd_data, e_data);
    end
  end

  task automatic acc(input logic r, input logic w, input logic v,
                     input logic [15:0] a, input logic [15:0] d);
    RD      = r;
    WR      = w;
    V       = v;
    Addr    = a;
    wr_data = d;
    @(posedge Clk1);
    @(negedge Clk1);
  endtask

  initial begin
    Reset = 1'b1;
    acc(0, 0, 0, 16'h0000, 16'h0000);
    acc(1, 0, 1, 16'h0001, 16'h0000);
    chk16("lit_rst_rd_data", rd_data, 16'h0000);
    chk1("lit_rst_rd_valid", rd_valid, 1'b0);
    chk1("lit_rst_err", err, 1'b0);
    chk16("lit_rst_bidx", 16'(burst_idx), 16'h0000);
    Reset = 1'b0;

    acc(0, 1, 0, 16'h0000, 16'hAAAA);
    acc(0, 1, 0, 16'h0003, 16'h3333);
    for (int i = 0; i < 16; i++)
      acc(0, 1, 0, 16'h0100 + 16'(i), 16'h1000 + 16'(i * 17));

    acc(0, 1, 0, 16'h0005, 16'hBEEF);
    acc(1, 0, 0, 16'h0005, 16'h0000);
    chk16("lit_beef_data", rd_data, 16'hBEEF);
    chk1("lit_beef_valid", rd_valid, 1'b1);
    acc(0, 0, 0, 16'h0000, 16'h0000);
    chk1("lit_idle_valid", rd_valid, 1'b0);
    chk16("lit_hold_data", rd_data, 16'hBEEF);

    acc(1, 0, 0, 16'h0400, 16'h0000);
    chk16("lit_ill_data", rd_data, 16'h0000);
    chk1("lit_ill_valid", rd_valid, 1'b1);
    chk1("lit_ill_err", err, 1'b1);
    acc(0, 0, 0, 16'h0000, 16'h0000);
    chk1("lit_err_pulse", err, 1'b0);
    acc(0, 1, 0, 16'h0400, 16'h1234);
    chk1("lit_ill_wr_err", err, 1'b1);
    acc(1, 0, 0, 16'h0000, 16'h0000);
    chk16("lit_ill_wr_mem0", rd_data, 16'hAAAA);

    acc(1, 1, 0, 16'h0003, 16'hDEAD);
    chk1("lit_both_err", err, 1'b1);
    chk1("lit_both_valid", rd_valid, 1'b0);
    acc(1, 0, 0, 16'h0003, 16'h0000);
    chk16("lit_both_mem3", rd_data, 16'h3333);

    for (int i = 0; i < 16; i++) begin
      acc(1, 0, 1, 16'h0100 + 16'(i), 16'h0000);
      chk16("lit_rb_idx", 16'(burst_idx), BURST ? 16'(i) : 16'h0000);
      chk1("lit_rb_seq", seq_err, 1'b0);
      chk16("lit_rb_data", rd_data, 16'h1000 + 16'(i * 17));
    end
    acc(1, 0, 1, 16'h0050, 16'h0000);
    chk1("lit_rb_idle_seq", seq_err, 1'b0);
    chk16("lit_rb_idle_idx", 16'(burst_idx), 16'h0000);
    acc(0, 0, 0, 16'h0000, 16'h0000);

    acc(0, 1, 1, 16'h0020, 16'h00A0);
    acc(0, 1, 1, 16'h0021, 16'h00A1);
    acc(0, 1, 1, 16'h0023, 16'h00A3);
    chk1("lit_wb_seq", seq_err, BURST);
    acc(1, 0, 0, 16'h0023, 16'h0000);
    chk16("lit_wb_landed", rd_data, 16'h00A3);
    chk1("lit_wb_seq_pulse", seq_err, 1'b0);

    for (int i = 0; i < 5; i++)
      acc(1, 0, 1, 16'h0100 + 16'(i), 16'h0000);
    Reset = 1'b1;
    acc(1, 0, 1, 16'h0105, 16'h0000);
    chk16("lit_mr_idx", 16'(burst_idx), 16'h0000);
    chk1("lit_mr_valid", rd_valid, 1'b0);
    chk1("lit_mr_seq", seq_err, 1'b0);
    Reset = 1'b0;
    acc(1, 0, 1, 16'h0106, 16'h0000);
    chk16("lit_mr_restart_idx", 16'(burst_idx), 16'h0000);
    chk16("lit_mr_data", rd_data, 16'h1066);

    acc(0, 1, 1, 16'h0030, 16'h0001);
    acc(0, 1, 1, 16'h0031, 16'h0002);
    acc(0, 1, 0, 16'h0035, 16'h0003);
    chk1("lit_vdrop_seq", seq_err, 1'b0);

    acc(1, 0, 1, 16'h0040, 16'h0000);
    acc(0, 1, 1, 16'h0041, 16'h0005);
    chk1("lit_dir_seq", seq_err, BURST);

    acc(1, 0, 1, 16'h0060, 16'h0000);
    acc(0, 0, 1, 16'h0061, 16'h0000);
    chk1("lit_noacc_seq", seq_err, BURST);

    acc(0, 1, 1, 16'h0070, 16'h0007);
    acc(0, 1, 1, 16'h0400, 16'h0008);
    chk1("lit_illb_err", err, 1'b1);
    chk1("lit_illb_seq", seq_err, BURST);

    acc(0, 0, 0, 16'h0000, 16'h0000);
    acc(0, 0, 0, 16'h0000, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
